// File: rtl/display_scan_ctrl_pkg.sv
// Shared definitions for the 4-digit display scan controller: FSM states,
// digit indices and small decode helpers.
package display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BLANK = 2'b01,
    ST_SHOW  = 2'b10
  } state_t;

  localparam logic [1:0] DIGIT_0 = 2'd0;
  localparam logic [1:0] DIGIT_1 = 2'd1;
  localparam logic [1:0] DIGIT_2 = 2'd2;
  localparam logic [1:0] DIGIT_3 = 2'd3;

  localparam logic [3:0] DIGITS_OFF = 4'b1111;

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    onehot = 4'b0001 << idx;
  endfunction

  // Returns DIGIT_0 for an empty mask; callers qualify with mask != 0.
  function automatic logic [1:0] lowest_set(input logic [3:0] m);
    if (m[0])      lowest_set = DIGIT_0;
    else if (m[1]) lowest_set = DIGIT_1;
    else if (m[2]) lowest_set = DIGIT_2;
    else if (m[3]) lowest_set = DIGIT_3;
    else           lowest_set = DIGIT_0;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Pattern/strobe inputs and mux/enable outputs of the display scan controller.
interface display_scan_ctrl_if #(
  parameter int DATA_WIDTH = 7
);
  logic                  enable;
  logic                  load;
  logic [DATA_WIDTH-1:0] seg_a;
  logic [DATA_WIDTH-1:0] seg_b;
  logic [DATA_WIDTH-1:0] seg_c;
  logic [DATA_WIDTH-1:0] seg_d;
  logic [3:0]            digit_mask;
  logic [DATA_WIDTH-1:0] out_a;
  logic [DATA_WIDTH-1:0] out_b;
  logic [DATA_WIDTH-1:0] out_c;
  logic [DATA_WIDTH-1:0] out_d;
  logic [1:0]            select;
  logic [3:0]            digit_n;
  logic                  frame_start;
  logic                  pending;

  modport master (
    output enable, load, seg_a, seg_b, seg_c, seg_d, digit_mask,
    input  out_a, out_b, out_c, out_d, select, digit_n, frame_start, pending
  );

  modport slave (
    input  enable, load, seg_a, seg_b, seg_c, seg_d, digit_mask,
    output out_a, out_b, out_c, out_d, select, digit_n, frame_start, pending
  );
endinterface

// File: rtl/display_scan_ctrl_slot_timer.sv
// Digit-slot timer: counts 0..PRESCALE-1 and flags the last blank cycle and
// the last cycle of the slot.
module slot_timer #(
  parameter int PRESCALE = 50000,
  parameter int BLANK    = 500
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic blank_done,
  output logic slot_done
);

  localparam int TW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [TW-1:0] LAST       = TW'(PRESCALE - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'((BLANK > 0) ? BLANK - 1 : 0);

  logic [TW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (r_count == LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign slot_done  = (r_count == LAST);
  assign blank_done = (BLANK > 0) && (r_count == BLANK_LAST);

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexing scan controller for a 4-digit 7-segment display with
// frame-synchronous double-buffered patterns and anti-ghosting blanking.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int DATA_WIDTH = 7,
  parameter int PRESCALE   = 50000,
  parameter int BLANK      = 500
) (
  input logic clk,
  input logic reset,
  display_scan_ctrl_if.slave bus
);

  state_t                r_state;
  logic [1:0]            r_select;
  logic [3:0]            r_digit_n;
  logic                  r_pending;
  logic                  r_frame_start;
  logic [DATA_WIDTH-1:0] r_stg_a, r_stg_b, r_stg_c, r_stg_d;
  logic [DATA_WIDTH-1:0] r_out_a, r_out_b, r_out_c, r_out_d;

  logic       w_blank_done;
  logic       w_slot_done;
  logic       w_clear;
  logic       w_mask_any;
  logic [1:0] w_lowest;
  logic [1:0] w_next_sel;
  logic       w_slot_frame;
  logic       w_boundary;

  // Upward search modulo 4 starting just above sel; i=4 revisits sel itself.
  function automatic logic [1:0] next_set(input logic [1:0] sel, input logic [3:0] m);
    logic       found;
    logic [1:0] idx;
    next_set = sel;
    found    = 1'b0;
    for (int unsigned i = 1; i <= 4; i++) begin
      idx = sel + 2'(i);
      if (!found && m[idx]) begin
        next_set = idx;
        found    = 1'b1;
      end
    end
  endfunction

  assign w_clear      = !bus.enable || (r_state == ST_IDLE);
  assign w_mask_any   = |bus.digit_mask;
  assign w_lowest     = lowest_set(bus.digit_mask);
  assign w_next_sel   = next_set(r_select, bus.digit_mask);
  assign w_slot_frame = (w_next_sel <= r_select) || (w_next_sel == w_lowest);

  assign w_boundary = bus.enable && w_mask_any &&
                      ((r_state == ST_IDLE) ||
                       ((r_state == ST_SHOW) && w_slot_done && w_slot_frame));

  slot_timer #(
    .PRESCALE (PRESCALE),
    .BLANK    (BLANK)
  ) u_slot_timer (
    .clk        (clk),
    .reset      (reset),
    .clear      (w_clear),
    .blank_done (w_blank_done),
    .slot_done  (w_slot_done)
  );

  // digit_n is computed from the live mask so a cleared digit darkens next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_select  <= DIGIT_0;
      r_digit_n <= DIGITS_OFF;
    end else if (!bus.enable) begin
      r_state   <= ST_IDLE;
      r_digit_n <= DIGITS_OFF;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_digit_n <= DIGITS_OFF;
          if (w_mask_any) begin
            r_select <= w_lowest;
            if (BLANK == 0) begin
              r_state   <= ST_SHOW;
              r_digit_n <= ~(onehot(w_lowest) & bus.digit_mask);
            end else begin
              r_state <= ST_BLANK;
            end
          end
        end
        ST_BLANK: begin
          if (w_blank_done) begin
            r_state   <= ST_SHOW;
            r_digit_n <= ~(onehot(r_select) & bus.digit_mask);
          end else begin
            r_digit_n <= DIGITS_OFF;
          end
        end
        ST_SHOW: begin
          if (w_slot_done) begin
            if (!w_mask_any) begin
              r_state   <= ST_IDLE;
              r_digit_n <= DIGITS_OFF;
            end else begin
              r_select <= w_next_sel;
              if (BLANK == 0) begin
                r_state   <= ST_SHOW;
                r_digit_n <= ~(onehot(w_next_sel) & bus.digit_mask);
              end else begin
                r_state   <= ST_BLANK;
                r_digit_n <= DIGITS_OFF;
              end
            end
          end else begin
            r_digit_n <= ~(onehot(r_select) & bus.digit_mask);
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_digit_n <= DIGITS_OFF;
        end
      endcase
    end
  end

  // A load on a boundary cycle lands in staging after the shadow copies the old data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stg_a       <= '0;
      r_stg_b       <= '0;
      r_stg_c       <= '0;
      r_stg_d       <= '0;
      r_out_a       <= '0;
      r_out_b       <= '0;
      r_out_c       <= '0;
      r_out_d       <= '0;
      r_pending     <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      if (w_boundary && r_pending) begin
        r_out_a       <= r_stg_a;
        r_out_b       <= r_stg_b;
        r_out_c       <= r_stg_c;
        r_out_d       <= r_stg_d;
        r_frame_start <= 1'b1;
        r_pending     <= 1'b0;
      end
      if (bus.load) begin
        r_stg_a   <= bus.seg_a;
        r_stg_b   <= bus.seg_b;
        r_stg_c   <= bus.seg_c;
        r_stg_d   <= bus.seg_d;
        r_pending <= 1'b1;
      end
    end
  end

  assign bus.out_a       = r_out_a;
  assign bus.out_b       = r_out_b;
  assign bus.out_c       = r_out_c;
  assign bus.out_d       = r_out_d;
  assign bus.select      = r_select;
  assign bus.digit_n     = r_digit_n;
  assign bus.frame_start = r_frame_start;
  assign bus.pending     = r_pending;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with PRESCALE=8, BLANK=2; expected
// per-cycle outputs are queued ahead of each run and compared in order.
module tb_display_scan_ctrl;

  localparam int DW = 7;
  localparam int PS = 8;
  localparam int BL = 2;

  logic clk;
  logic reset;

  display_scan_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  display_scan_ctrl #(
    .DATA_WIDTH (DW),
    .PRESCALE   (PS),
    .BLANK      (BL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef enum int {F_SEL, F_DN, F_OUT, F_FS, F_PEND} fld_t;
  typedef struct {
    int          k;
    fld_t        fld;
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input fld_t f);
    case (f)
      F_SEL:   return 32'(bus.select);
      F_DN:    return 32'(bus.digit_n);
      F_OUT:   return 32'({bus.out_a, bus.out_b, bus.out_c, bus.out_d});
      F_FS:    return 32'(bus.frame_start);
      default: return 32'(bus.pending);
    endcase
  endfunction

  task automatic push(input int k, input fld_t f, input logic [31:0] v, input string name);
    exp_t e;
    e.k   = k;
    e.fld = f;
    e.val = v;
    e.tag = $sformatf("%s@%0d", name, k);
    q.push_back(e);
  endtask

  task automatic drain(input int k);
    exp_t e;
    while (q.size() > 0 && q[0].k == k) begin
      e = q.pop_front();
      check(e.tag, observe(e.fld), e.val);
    end
  endtask

  function automatic logic [3:0] scan_dn(input int off, input int sel);
    logic [3:0] oh;
    oh = 4'b0001 << sel;
    return (off < BL) ? 4'b1111 : ~oh;
  endfunction

  function automatic logic [31:0] pk(input logic [6:0] a, input logic [6:0] b,
                                     input logic [6:0] c, input logic [6:0] d);
    return 32'({a, b, c, d});
  endfunction

  task automatic set_segs(input logic [6:0] a, input logic [6:0] b,
                          input logic [6:0] c, input logic [6:0] d);
    bus.seg_a = a;
    bus.seg_b = b;
    bus.seg_c = c;
    bus.seg_d = d;
  endtask

  initial begin
    logic [31:0] p_a, p_b, p_c, p_d, exp_out;
    int          sel;
    logic [3:0]  dn;

    p_a = pk(7'h3F, 7'h06, 7'h5B, 7'h4F);
    p_b = pk(7'h66, 7'h6D, 7'h7D, 7'h07);
    p_c = pk(7'h7F, 7'h6F, 7'h77, 7'h7C);
    p_d = pk(7'h39, 7'h5E, 7'h79, 7'h71);

    reset          = 1'b1;
    bus.enable     = 1'b0;
    bus.load       = 1'b0;
    bus.digit_mask = 4'b0000;
    set_segs('0, '0, '0, '0);
    step();
    step();
    reset = 1'b0;
    step();
    check("rst_sel", 32'(bus.select), 32'd0);
    check("rst_dn", 32'(bus.digit_n), 32'hF);
    check("rst_out", observe(F_OUT), 32'd0);
    check("rst_pend", 32'(bus.pending), 32'd0);
    check("rst_fs", 32'(bus.frame_start), 32'd0);

    // Full mask: digits 0..3 then back to 0, 8 cycles each.
    for (int k = 0; k < 40; k++) begin
      sel = (k / PS) % 4;
      push(k, F_SEL, 32'(sel), "A_sel");
      push(k, F_DN, 32'(scan_dn(k % PS, sel)), "A_dn");
    end
    bus.digit_mask = 4'b1111;
    bus.enable     = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step();
      drain(k);
    end
    check("A_drain", 32'(q.size()), 32'd0);
    bus.enable = 1'b0;
    step();
    check("A_off", 32'(bus.digit_n), 32'hF);

    // Sparse mask 0101: alternates 0 and 2.
    for (int k = 0; k < 32; k++) begin
      sel = ((k / PS) % 2) * 2;
      push(k, F_SEL, 32'(sel), "B_sel");
      push(k, F_DN, 32'(scan_dn(k % PS, sel)), "B_dn");
    end
    bus.digit_mask = 4'b0101;
    bus.enable     = 1'b1;
    for (int k = 0; k < 32; k++) begin
      step();
      drain(k);
      check($sformatf("B_d13@%0d", k), 32'({bus.digit_n[3], bus.digit_n[1]}), 32'h3);
    end
    check("B_drain", 32'(q.size()), 32'd0);
    bus.enable = 1'b0;
    step();

    // Loads mid-frame and on a boundary, mask clear, single-digit rescan.
    for (int k = 0; k < 118; k++) begin
      if (k < 100) begin
        sel = (k / PS) % 4;
        dn  = scan_dn(k % PS, sel);
      end else if (k < 106) begin
        sel = 0;
        dn  = 4'b1111;
      end else begin
        sel = 1;
        dn  = ((k - 106) % PS < BL) ? 4'b1111 : 4'b1101;
      end
      if (k < 32)       exp_out = 32'd0;
      else if (k < 64)  exp_out = p_a;
      else if (k < 96)  exp_out = p_b;
      else if (k < 114) exp_out = p_c;
      else              exp_out = p_d;
      push(k, F_SEL, 32'(sel), "C_sel");
      push(k, F_DN, 32'(dn), "C_dn");
      push(k, F_OUT, exp_out, "C_out");
      push(k, F_FS, 32'(k == 32 || k == 64 || k == 96 || k == 114), "C_fs");
      push(k, F_PEND, 32'((k >= 10 && k < 32) || (k >= 40 && k < 96) ||
                          (k >= 110 && k < 114)), "C_pend");
    end
    bus.digit_mask = 4'b1111;
    bus.enable     = 1'b1;
    for (int k = 0; k < 118; k++) begin
      step();
      drain(k);
      bus.load = (k == 9 || k == 39 || k == 63 || k == 109);
      case (k)
        9:       set_segs(7'h3F, 7'h06, 7'h5B, 7'h4F);
        39:      set_segs(7'h66, 7'h6D, 7'h7D, 7'h07);
        63:      set_segs(7'h7F, 7'h6F, 7'h77, 7'h7C);
        109:     set_segs(7'h39, 7'h5E, 7'h79, 7'h71);
        default: ;
      endcase
      if (k == 99)  bus.digit_mask = 4'b0000;
      if (k == 105) bus.digit_mask = 4'b0010;
    end
    check("C_drain", 32'(q.size()), 32'd0);

    // Enable drop mid-SHOW, then reset mid-SHOW with data pending.
    bus.enable = 1'b0;
    step();
    check("en_drop_dn", 32'(bus.digit_n), 32'hF);
    check("en_drop_out", observe(F_OUT), p_d);
    bus.digit_mask = 4'b1110;
    bus.enable     = 1'b1;
    step();
    check("reen_sel", 32'(bus.select), 32'd1);
    check("reen_dn", 32'(bus.digit_n), 32'hF);
    step();
    step();
    check("reen_show", 32'(bus.digit_n), 32'hD);
    bus.load = 1'b1;
    set_segs(7'h01, 7'h02, 7'h04, 7'h08);
    step();
    bus.load = 1'b0;
    check("pend_pre_rst", 32'(bus.pending), 32'd1);
    check("dn_pre_rst", 32'(bus.digit_n), 32'hD);
    reset = 1'b1;
    step();
    check("mrst_dn", 32'(bus.digit_n), 32'hF);
    check("mrst_sel", 32'(bus.select), 32'd0);
    check("mrst_out", observe(F_OUT), 32'd0);
    check("mrst_pend", 32'(bus.pending), 32'd0);
    check("mrst_fs", 32'(bus.frame_start), 32'd0);
    reset = 1'b0;
    step();
    check("post_rst_sel", 32'(bus.select), 32'd1);
    check("post_rst_fs", 32'(bus.frame_start), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
